hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//   Consumer-side control for the MIPS pipeline registers. Reads ID-stage source
//   registers and the ID/EX load destination, then drives the write enables and
//   bubble/flush controls of PC, IF/ID and ID/EX.
//   Inserts exactly one stall cycle per load-use hazard via a 2-state FSM.
//   Flushes younger stages on a taken branch (EX) or a jump (ID).
//   Keeps saturating stall and flush counters for performance debug.
// PARAMETERS
//   REG_W  5   register-address width
//   CNT_W  16  width of the stall_count and flush_count counters
// PORTS
//   clk           in   1      pipeline clock, rising edge
//   reset         in   1      asynchronous, active-low reset
//   id_rs         in   REG_W  rs field of the instruction in IF/ID
//   id_rt         in   REG_W  rt field of the instruction in IF/ID
//   id_uses_rt    in   1      1 = ID instruction reads rt as a source
//   ex_mem_read   in   1      1 = ID/EX instruction is a load
//   ex_rt         in   REG_W  destination register of the ID/EX load
//   branch_taken  in   1      branch resolved taken in EX this cycle
//   jump          in   1      jump decoded in ID this cycle
//   clear_counts  in   1      synchronous clear of both counters
//   pc_write      out  1      PC write enable
//   if_id_write   out  1      IF/ID write enable (0 = hold)
//   id_ex_bubble  out  1      1 = ID/EX loads all-zero control (NOP)
//   if_id_flush   out  1      1 = IF/ID loads NOP
//   stall_count   out  CNT_W  number of load-use stall cycles
//   flush_count   out  CNT_W  number of flush events (branch or jump)
// BEHAVIOUR
//   - States: RUN, STALL. Reset (reset=0) forces state RUN and both counters to 0
//     immediately; the state register and counters update on posedge clk.
//   - While reset=0, outputs are forced: pc_write=0, if_id_write=0,
//     id_ex_bubble=1, if_id_flush=1.
//   - Hazard detection (combinational):
//     lu = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
//   - Outputs are combinational from state and inputs, so they act in the same cycle.
//     Default: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0.
//   - Priority: branch_taken > jump > lu.
//   - branch_taken=1 (any state): if_id_flush=1, id_ex_bubble=1, pc_write=1;
//     next state RUN; flush_count+1.
//   - jump=1 and no branch: if_id_flush=1, pc_write=1; state unchanged except
//     STALL->RUN; flush_count+1.
//   - RUN and lu and no branch/jump: pc_write=0, if_id_write=0, id_ex_bubble=1;
//     next state STALL; stall_count+1.
//   - STALL: lu is ignored (no back-to-back stall) and default outputs apply;
//     next state RUN.
//   - Stall latency: exactly 1 cycle per load-use. The dependent instruction
//     leaves ID on the cycle after the stall.
//   - Counters saturate at {CNT_W{1'b1}} with no wrap.
//   - clear_counts=1 zeroes both counters at the next edge and overrides any
//     increment in that cycle.
//   - Reset asserted mid-STALL: state goes to RUN at once; no stall is pending
//     after reset is released.
//   - ex_rt==0 never causes a stall ($zero is not a true dependency).
// TESTING
//   1. Reset low for 3 cycles, then high -> outputs 0/0/1/1 during reset;
//      then 1/1/0/0; counters 0.
//   2. lw $t0 in EX (ex_mem_read=1, ex_rt=8), id_rs=8 -> 1 cycle with
//      pc_write=0, if_id_write=0, id_ex_bubble=1; then normal; stall_count=1.
//   3. ex_rt=0, id_rs=0, ex_mem_read=1 -> no stall; stall_count stays 0.
//   4. lu and branch_taken in the same cycle -> if_id_flush=1, id_ex_bubble=1,
//      pc_write=1, state RUN, flush_count=1, stall_count=0.
//   5. id_uses_rt=0, ex_rt==id_rt=9, ex_mem_read=1 -> no stall.
//      Same case with id_uses_rt=1 -> 1-cycle stall.
//   6. Force stall_count to 16'hFFFF via 65535 stalls, then one more -> stays
//      FFFF. Then clear_counts=1 together with lu -> stall_count=0.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// ============================================================================
// hazard_stall_unit_if
// Pipeline hazard control bundle: ID/EX operand info in, PC/IF/ID/ID/EX
// controls and performance counters out.
// Revision: 1.0
// ============================================================================
interface hazard_stall_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rt;
    logic             branch_taken;
    logic             jump;
    logic             clear_counts;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, jump, clear_counts,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush,
               stall_count, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, jump, clear_counts,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush,
               stall_count, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// hazard_stall_unit
// Load-use stall insertion and branch/jump flush control for a MIPS pipeline,
// with saturating stall/flush event counters.
// Revision: 1.0
// ============================================================================
module hazard_stall_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  wire logic      clk,
    input  wire logic      reset,
    hazard_stall_unit_if.slave hz
);
    localparam logic [0:0]       c_RUN     = 1'b0;
    localparam logic [0:0]       c_STALL   = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [REG_W-1:0] c_ZERO    = '0;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_lu;
    logic             w_stall_ev;
    logic             w_flush_ev;
    logic             w_pc_write;
    logic             w_if_id_write;
    logic             w_id_ex_bubble;
    logic             w_if_id_flush;

    // $zero is never a real producer, so a load to it cannot create a hazard
    assign w_lu = hz.ex_mem_read && (hz.ex_rt != c_ZERO) &&
                  ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    assign w_flush_ev = hz.branch_taken || hz.jump;
    assign w_stall_ev = (r_state == c_RUN) && w_lu && !w_flush_ev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = c_RUN;
        if (w_stall_ev) begin
            w_state_next = c_STALL;
        end
    end

    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_id_ex_bubble = 1'b0;
        w_if_id_flush  = 1'b0;
        if (!reset) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
            w_if_id_flush  = 1'b1;
        end else if (hz.branch_taken) begin
            w_id_ex_bubble = 1'b1;
            w_if_id_flush  = 1'b1;
        end else if (hz.jump) begin
            w_if_id_flush  = 1'b1;
        end else if (w_stall_ev) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (hz.clear_counts) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_ev && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_ev && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign hz.pc_write     = w_pc_write;
    assign hz.if_id_write  = w_if_id_write;
    assign hz.id_ex_bubble = w_id_ex_bubble;
    assign hz.if_id_flush  = w_if_id_flush;
    assign hz.stall_count  = r_stall_cnt;
    assign hz.flush_count  = r_flush_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_stall_unit
// Self-checking bench: directed scenarios plus randomized traffic against a
// rule-level model; a narrow-counter instance exercises saturation.
// Revision: 1.0
// ============================================================================
module tb_hazard_stall_unit;
    localparam int REG_W = 5;
    localparam int CNT_W = 16;
    localparam int SAT_W = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif ();
    hazard_stall_unit_if #(.REG_W(REG_W), .CNT_W(SAT_W)) sif ();

    assign sif.id_rs        = hif.id_rs;
    assign sif.id_rt        = hif.id_rt;
    assign sif.id_uses_rt   = hif.id_uses_rt;
    assign sif.ex_mem_read  = hif.ex_mem_read;
    assign sif.ex_rt        = hif.ex_rt;
    assign sif.branch_taken = hif.branch_taken;
    assign sif.jump         = hif.jump;
    assign sif.clear_counts = hif.clear_counts;

    hazard_stall_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    hazard_stall_unit #(.REG_W(REG_W), .CNT_W(SAT_W)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .hz    (sif)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: did the previous cycle insert a stall, and raw event totals
    bit m_stalled;
    int m_stall;
    int m_flush;

    function automatic bit ref_lu();
        return hif.ex_mem_read && (hif.ex_rt != 0) &&
               ((hif.ex_rt == hif.id_rs) || (hif.id_uses_rt && (hif.ex_rt == hif.id_rt)));
    endfunction

    function automatic bit ref_stall();
        return ref_lu() && !m_stalled && !hif.branch_taken && !hif.jump;
    endfunction

    // {pc_write, if_id_write, id_ex_bubble, if_id_flush}
    function automatic logic [3:0] exp_outs();
        if (!reset)            return 4'b0011;
        if (hif.branch_taken)  return 4'b1111;
        if (hif.jump)          return 4'b1101;
        if (ref_stall())       return 4'b0010;
        return 4'b1100;
    endfunction

    function automatic logic [3:0] act_outs();
        return {hif.pc_write, hif.if_id_write, hif.id_ex_bubble, hif.if_id_flush};
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input bit uses,
                         input bit mr, input logic [4:0] ert, input bit br,
                         input bit jp, input bit clr);
        hif.id_rs        = rs;
        hif.id_rt        = rt;
        hif.id_uses_rt   = uses;
        hif.ex_mem_read  = mr;
        hif.ex_rt        = ert;
        hif.branch_taken = br;
        hif.jump         = jp;
        hif.clear_counts = clr;
        #1;
    endtask

    task automatic idle(input bit clr);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, clr);
    endtask

    task automatic tick();
        bit st;
        if (!reset) begin
            m_stalled = 1'b0;
            m_stall   = 0;
            m_flush   = 0;
        end else begin
            st = ref_stall();
            if (hif.clear_counts) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (st) m_stall++;
                if (hif.branch_taken || hif.jump) m_flush++;
            end
            m_stalled = st;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (act_outs() !== 4'b0011) begin
                failures++;
                $display("FAIL reset_outs cyc=%0d got=%b exp=0011", i, act_outs());
            end
            checks++;
        end
        if (hif.stall_count !== 16'd0 || hif.flush_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_counts got=%0d/%0d exp=0/0", hif.stall_count, hif.flush_count);
        end
        checks++;
        reset = 1'b1;
        #1;
        if (act_outs() !== 4'b1100) begin
            failures++;
            $display("FAIL reset_release_outs got=%b exp=1100", act_outs());
        end
        checks++;
        tick();
        if (hif.stall_count !== 16'd0 || hif.flush_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_release_counts got=%0d/%0d exp=0/0", hif.stall_count, hif.flush_count);
        end
        checks++;
    endtask

    task automatic test_load_use();
        idle(1'b1); tick();
        drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        if (act_outs() !== 4'b0010) begin
            failures++;
            $display("FAIL load_use_stall got=%b exp=0010", act_outs());
        end
        checks++;
        tick();
        if (act_outs() !== 4'b1100) begin
            failures++;
            $display("FAIL load_use_release got=%b exp=1100", act_outs());
        end
        checks++;
        if (hif.stall_count !== 16'd1) begin
            failures++;
            $display("FAIL load_use_count got=%0d exp=1", hif.stall_count);
        end
        checks++;
        idle(1'b0); tick();
        if (act_outs() !== 4'b1100 || hif.stall_count !== 16'd1) begin
            failures++;
            $display("FAIL load_use_after got=%b/%0d exp=1100/1", act_outs(), hif.stall_count);
        end
        checks++;
    endtask

    task automatic test_zero_reg();
        idle(1'b1); tick();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        if (act_outs() !== 4'b1100) begin
            failures++;
            $display("FAIL zero_reg_outs got=%b exp=1100", act_outs());
        end
        checks++;
        tick();
        if (hif.stall_count !== 16'd0) begin
            failures++;
            $display("FAIL zero_reg_count got=%0d exp=0", hif.stall_count);
        end
        checks++;
    endtask

    task automatic test_branch_priority();
        idle(1'b1); tick();
        drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
        if (act_outs() !== 4'b1111) begin
            failures++;
            $display("FAIL branch_outs got=%b exp=1111", act_outs());
        end
        checks++;
        tick();
        if (hif.flush_count !== 16'd1 || hif.stall_count !== 16'd0) begin
            failures++;
            $display("FAIL branch_counts got=%0d/%0d exp=1/0", hif.flush_count, hif.stall_count);
        end
        checks++;
        // Same hazard still present: state must be RUN, so it stalls now
        drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        if (act_outs() !== 4'b0010) begin
            failures++;
            $display("FAIL branch_then_lu got=%b exp=0010", act_outs());
        end
        checks++;
        tick();
        drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0);
        if (act_outs() !== 4'b1101) begin
            failures++;
            $display("FAIL jump_in_stall got=%b exp=1101", act_outs());
        end
        checks++;
        tick();
        drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        if (act_outs() !== 4'b0010 || hif.flush_count !== 16'd2 || hif.stall_count !== 16'd1) begin
            failures++;
            $display("FAIL jump_to_run got=%b/%0d/%0d exp=0010/2/1",
                     act_outs(), hif.flush_count, hif.stall_count);
        end
        checks++;
        tick();
        idle(1'b0); tick();
    endtask

    task automatic test_uses_rt();
        idle(1'b1); tick();
        drive(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        if (act_outs() !== 4'b1100) begin
            failures++;
            $display("FAIL rt_unused got=%b exp=1100", act_outs());
        end
        checks++;
        tick();
        drive(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        if (act_outs() !== 4'b0010) begin
            failures++;
            $display("FAIL rt_used got=%b exp=0010", act_outs());
        end
        checks++;
        tick();
        if (act_outs() !== 4'b1100 || hif.stall_count !== 16'd1) begin
            failures++;
            $display("FAIL rt_used_after got=%b/%0d exp=1100/1", act_outs(), hif.stall_count);
        end
        checks++;
        idle(1'b0); tick();
    endtask

    task automatic test_reset_mid_stall();
        drive(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        m_stalled = 1'b0;
        m_stall   = 0;
        m_flush   = 0;
        #1;
        if (act_outs() !== 4'b0011 || hif.stall_count !== 16'd0 || hif.flush_count !== 16'd0) begin
            failures++;
            $display("FAIL mid_stall_reset got=%b/%0d/%0d exp=0011/0/0",
                     act_outs(), hif.stall_count, hif.flush_count);
        end
        checks++;
        tick();
        reset = 1'b1;
        idle(1'b0);
        if (act_outs() !== 4'b1100) begin
            failures++;
            $display("FAIL mid_stall_idle got=%b exp=1100", act_outs());
        end
        checks++;
        drive(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        if (act_outs() !== 4'b0010) begin
            failures++;
            $display("FAIL mid_stall_fresh got=%b exp=0010", act_outs());
        end
        checks++;
        tick();
        idle(1'b0); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 31) == 0));
            if (act_outs() !== exp_outs()) begin
                failures++;
                $display("FAIL random_outs i=%0d got=%b exp=%b", i, act_outs(), exp_outs());
            end
            checks++;
            tick();
            if (hif.stall_count !== CNT_W'(sat(m_stall, CNT_W)) ||
                hif.flush_count !== CNT_W'(sat(m_flush, CNT_W)) ||
                sif.stall_count !== SAT_W'(sat(m_stall, SAT_W)) ||
                sif.flush_count !== SAT_W'(sat(m_flush, SAT_W))) begin
                failures++;
                $display("FAIL random_counts i=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", i,
                         hif.stall_count, hif.flush_count, sif.stall_count, sif.flush_count,
                         sat(m_stall, CNT_W), sat(m_flush, CNT_W),
                         sat(m_stall, SAT_W), sat(m_flush, SAT_W));
            end
            checks++;
        end
        idle(1'b0); tick();
    endtask

    task automatic test_saturation();
        idle(1'b1); tick();
        for (int i = 0; i < 70; i++) begin
            drive(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
            tick();
            drive(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
            if (act_outs() !== 4'b0010) begin
                failures++;
                $display("FAIL sat_stall i=%0d got=%b exp=0010", i, act_outs());
            end
            checks++;
            tick();
            idle(1'b0); tick();
        end
        if (sif.stall_count !== 6'h3F || sif.flush_count !== 6'h3F) begin
            failures++;
            $display("FAIL sat_narrow got=%0d/%0d exp=63/63", sif.stall_count, sif.flush_count);
        end
        checks++;
        if (hif.stall_count !== 16'd70 || hif.flush_count !== 16'd70) begin
            failures++;
            $display("FAIL sat_wide got=%0d/%0d exp=70/70", hif.stall_count, hif.flush_count);
        end
        checks++;
        drive(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
        if (act_outs() !== 4'b0010) begin
            failures++;
            $display("FAIL sat_clear_lu_outs got=%b exp=0010", act_outs());
        end
        checks++;
        tick();
        if (sif.stall_count !== 6'd0 || hif.stall_count !== 16'd0 || hif.flush_count !== 16'd0) begin
            failures++;
            $display("FAIL sat_clear got=%0d/%0d/%0d exp=0/0/0",
                     sif.stall_count, hif.stall_count, hif.flush_count);
        end
        checks++;
        idle(1'b0); tick();
    endtask

    initial begin
        reset = 1'b1;
        idle(1'b0);
        reset = 1'b0;
        m_stalled = 1'b0;
        m_stall   = 0;
        m_flush   = 0;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_priority();
        test_uses_rt();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
